ht_task_initiator: RTL and testbench

- Host-side initiator for the hash table pipeline: drives ht_task_if as master and consumes ht_res_if as slave.
- Accepts host commands (search/insert/delete with key/value) through a valid/ready port and registers them onto ht_task_out.
- Bounds the number of in-flight tasks, watches for lost results with a timeout, and returns results to the host in order.
- Sits between the CPU/test host and the hash table top.

---
 rtl/hash_table_pkg.sv | 42 ++++
 rtl/ht_if.sv | 39 +++
 rtl/ht_init_watchdog.sv | 43 ++++
 rtl/ht_task_initiator.sv | 183 ++++++++++++++++++
 tb/tb_ht_task_initiator.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hash_table_pkg.sv
// Shared hash table types: commands, result codes, result bundle
// and the initiator FSM state encoding.
package hash_table;

  localparam int KEY_WIDTH   = 32;
  localparam int VALUE_WIDTH = 32;

  typedef enum logic [1:0] {
    CMD_SEARCH = 2'd0,
    CMD_INSERT = 2'd1,
    CMD_DELETE = 2'd2
  } ht_command_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND                    = 3'd0,
    SEARCH_NOT_FOUND                = 3'd1,
    INSERT_SUCCESS                  = 3'd2,
    INSERT_SUCCESS_SAME_KEY         = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
    DELETE_SUCCESS                  = 3'd5,
    DELETE_NOT_SUCCESS_NO_ENTRY     = 3'd6
  } ht_rescode_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    ht_command_t            cmd;
    ht_rescode_t            rescode;
  } ht_result_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ERROR = 2'd2
  } ht_init_state_t;

  function automatic logic is_not_found(ht_rescode_t c);
    return (c == SEARCH_NOT_FOUND) ||
           (c == DELETE_NOT_SUCCESS_NO_ENTRY);
  endfunction

endpackage

// File: rtl/ht_if.sv
// Task and result handshake interfaces between the initiator
// and the hash table pipeline.
interface ht_task_if;
  import hash_table::*;

  logic [KEY_WIDTH-1:0]   key;
  logic [VALUE_WIDTH-1:0] value;
  ht_command_t            cmd;
  logic                   valid;
  logic                   ready;

  modport master (
    output key, value, cmd, valid,
    input  ready
  );

  modport slave (
    input  key, value, cmd, valid,
    output ready
  );
endinterface

interface ht_res_if;
  import hash_table::*;

  ht_result_t result;
  logic       valid;
  logic       ready;

  modport master (
    output result, valid,
    input  ready
  );

  modport slave (
    input  result, valid,
    output ready
  );
endinterface

// File: rtl/ht_init_watchdog.sv
// Lost-result watchdog: counts idle cycles while tasks are
// outstanding and flags a timeout at TIMEOUT_CYCLES-1.
module ht_init_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inflight_nz_i,
  input  logic res_hs_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic timeout_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr_i) begin
      timer_d = '0;
    end else if (hold_i) begin
      timer_d = timer_q;
    end else if (res_hs_i || !inflight_nz_i) begin
      timer_d = '0;
    end else if (timer_q != LIMIT) begin
      timer_d = timer_q + 16'd1;
    end
  end

  assign timeout_o = !hold_i && inflight_nz_i &&
                     !res_hs_i && (timer_q == LIMIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/ht_task_initiator.sv
// Host-side hash table initiator with in-flight bound and timeout.
// Optional statistics counters: HT_TASK_INITIATOR_STATS_EN.
module ht_task_initiator
  import hash_table::*;
#(
  parameter int MAX_INFLIGHT   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   host_valid_i,
  output logic                   host_ready_o,
  input  ht_command_t            host_cmd_i,
  input  logic [KEY_WIDTH-1:0]   host_key_i,
  input  logic [VALUE_WIDTH-1:0] host_value_i,
  input  logic                   flush_i,
  input  logic                   clear_err_i,
  ht_task_if.master              ht_task_out,
  ht_res_if.slave                ht_res_in,
  output logic                   host_res_valid_o,
  input  logic                   host_res_ready_i,
  output ht_result_t             host_res_o,
  output logic [7:0]             inflight_o,
  output logic                   busy_o,
  output logic                   err_timeout_o,
  output logic                   err_unexpected_o
`ifdef HT_TASK_INITIATOR_STATS_EN
  ,
  output logic [31:0]            stat_tasks_o,
  output logic [31:0]            stat_results_o,
  output logic [31:0]            stat_not_found_o
`else
`endif
);

  localparam logic [7:0] MAX_IF = 8'(MAX_INFLIGHT);

  ht_init_state_t state_q, state_d;

  logic                   tv_q, tv_d;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] value_q;
  ht_command_t            cmd_q;
  logic [7:0]             inflight_q, inflight_d;
  logic                   err_to_q, err_to_d;
  logic                   err_un_q, err_un_d;

  logic host_hs, task_hs, pass, res_hs;
  logic fwd_hs, err_clr, timeout, in_err;

  assign in_err  = (state_q == ERROR);
  assign err_clr = in_err && clear_err_i;

  // Results only reach the host when something is outstanding.
  assign pass = !in_err && (inflight_q != 8'd0);
  assign ht_res_in.ready  = pass ? host_res_ready_i : 1'b1;
  assign host_res_valid_o = pass && ht_res_in.valid;
  assign host_res_o       = ht_res_in.result;
  assign res_hs = ht_res_in.valid && ht_res_in.ready;
  assign fwd_hs = pass && res_hs;

  assign host_ready_o = (state_q == RUN) &&
                        (inflight_q < MAX_IF) &&
                        (!tv_q || ht_task_out.ready);
  assign host_hs = host_valid_i && host_ready_o;
  assign task_hs = tv_q && ht_task_out.ready;

  assign ht_task_out.valid = tv_q;
  assign ht_task_out.key   = key_q;
  assign ht_task_out.value = value_q;
  assign ht_task_out.cmd   = cmd_q;

  assign inflight_o       = inflight_q;
  assign busy_o           = (inflight_q != 8'd0) || tv_q;
  assign err_timeout_o    = err_to_q;
  assign err_unexpected_o = err_un_q;

  ht_init_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .inflight_nz_i (inflight_q != 8'd0),
    .res_hs_i      (fwd_hs),
    .clr_i         (err_clr),
    .hold_i        (in_err),
    .timeout_o     (timeout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (timeout)      state_d = ERROR;
        else if (flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (timeout) state_d = ERROR;
        else if (inflight_q == 8'd0 && !tv_q)
          state_d = RUN;
      end
      ERROR: begin
        if (clear_err_i)
          state_d = flush_i ? DRAIN : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case (1'b1)
      err_clr:             inflight_d = 8'd0;
      host_hs && !fwd_hs:  inflight_d = inflight_q + 8'd1;
      fwd_hs && !host_hs:  inflight_d = inflight_q - 8'd1;
      default: ;
    endcase
  end

  always_comb begin
    tv_d = tv_q;
    if (task_hs) tv_d = 1'b0;
    if (host_hs) tv_d = 1'b1;
    err_to_d = err_to_q;
    if (clear_err_i) err_to_d = 1'b0;
    if (timeout)     err_to_d = 1'b1;
    err_un_d = err_un_q;
    if (clear_err_i) err_un_d = 1'b0;
    if (ht_res_in.valid && inflight_q == 8'd0)
      err_un_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      tv_q       <= 1'b0;
      key_q      <= '0;
      value_q    <= '0;
      cmd_q      <= CMD_SEARCH;
      inflight_q <= 8'd0;
      err_to_q   <= 1'b0;
      err_un_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tv_q       <= tv_d;
      inflight_q <= inflight_d;
      err_to_q   <= err_to_d;
      err_un_q   <= err_un_d;
      if (host_hs) begin
        key_q   <= host_key_i;
        value_q <= host_value_i;
        cmd_q   <= host_cmd_i;
      end
    end
  end

`ifdef HT_TASK_INITIATOR_STATS_EN
  logic [31:0] st_tasks_q, st_res_q, st_nf_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_tasks_q <= '0;
      st_res_q   <= '0;
      st_nf_q    <= '0;
    end else if (clear_err_i) begin
      st_tasks_q <= '0;
      st_res_q   <= '0;
      st_nf_q    <= '0;
    end else begin
      if (task_hs) st_tasks_q <= st_tasks_q + 32'd1;
      if (fwd_hs)  st_res_q   <= st_res_q + 32'd1;
      if (fwd_hs && is_not_found(ht_res_in.result.rescode))
        st_nf_q <= st_nf_q + 32'd1;
    end
  end

  assign stat_tasks_o     = st_tasks_q;
  assign stat_results_o   = st_res_q;
  assign stat_not_found_o = st_nf_q;
`else
`endif

endmodule

// File: tb/tb_ht_task_initiator.sv
// Directed self-checking bench for ht_task_initiator
// (MAX_INFLIGHT=8, TIMEOUT_CYCLES=16).
module tb_ht_task_initiator;
  import hash_table::*;

  logic clk = 1'b0;
  logic rst_i;
  logic host_valid_i, host_ready_o;
  ht_command_t host_cmd_i;
  logic [KEY_WIDTH-1:0] host_key_i;
  logic [VALUE_WIDTH-1:0] host_value_i;
  logic flush_i, clear_err_i;
  logic host_res_valid_o, host_res_ready_i;
  ht_result_t host_res_o;
  logic [7:0] inflight_o;
  logic busy_o, err_timeout_o, err_unexpected_o;
`ifdef HT_TASK_INITIATOR_STATS_EN
  logic [31:0] stat_tasks_o, stat_results_o, stat_not_found_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int acc;

  ht_task_if task_if ();
  ht_res_if  res_if ();

  always #5 clk = ~clk;

  ht_task_initiator #(
    .MAX_INFLIGHT   (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .host_valid_i     (host_valid_i),
    .host_ready_o     (host_ready_o),
    .host_cmd_i       (host_cmd_i),
    .host_key_i       (host_key_i),
    .host_value_i     (host_value_i),
    .flush_i          (flush_i),
    .clear_err_i      (clear_err_i),
    .ht_task_out      (task_if),
    .ht_res_in        (res_if),
    .host_res_valid_o (host_res_valid_o),
    .host_res_ready_i (host_res_ready_i),
    .host_res_o       (host_res_o),
    .inflight_o       (inflight_o),
    .busy_o           (busy_o),
    .err_timeout_o    (err_timeout_o),
    .err_unexpected_o (err_unexpected_o)
`ifdef HT_TASK_INITIATOR_STATS_EN
    ,
    .stat_tasks_o     (stat_tasks_o),
    .stat_results_o   (stat_results_o),
    .stat_not_found_o (stat_not_found_o)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    host_valid_i = 1'b0;
    host_cmd_i = CMD_SEARCH;
    host_key_i = '0;
    host_value_i = '0;
    flush_i = 1'b0;
    clear_err_i = 1'b0;
    host_res_ready_i = 1'b1;
    task_if.ready = 1'b1;
    res_if.valid = 1'b0;
    res_if.result = '{key: 32'h0, value: 32'h0,
                      cmd: CMD_SEARCH, rescode: SEARCH_FOUND};
    #3;
    chk("rst_host_ready", host_ready_o, 1'b1);
    chk("rst_task_valid", task_if.valid, 1'b0);
    chk("rst_res_valid", host_res_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_inflight", inflight_o, 8'd0);
    chk("rst_errs", {err_timeout_o, err_unexpected_o}, 2'b00);
    tick();
    tick();
    rst_i = 1'b1;

    host_valid_i = 1'b1;
    host_cmd_i = CMD_INSERT;
    host_key_i = 32'h1234;
    host_value_i = 32'h55;
    #1;
    chk("ins_ready", host_ready_o, 1'b1);
    tick();
    host_valid_i = 1'b0;
    chk("ins_task_valid", task_if.valid, 1'b1);
    chk("ins_task_key", task_if.key, 32'h1234);
    chk("ins_task_val", task_if.value, 32'h55);
    chk("ins_task_cmd", task_if.cmd, CMD_INSERT);
    chk("ins_inflight1", inflight_o, 8'd1);
    tick();
    chk("ins_task_done", task_if.valid, 1'b0);
    tick();
    tick();
    tick();
    res_if.result = '{key: 32'h1234, value: 32'h55,
                      cmd: CMD_INSERT, rescode: INSERT_SUCCESS};
    res_if.valid = 1'b1;
    #1;
    chk("ins_res_valid", host_res_valid_o, 1'b1);
    chk("ins_res_key", host_res_o.key, 32'h1234);
    chk("ins_res_ready", res_if.ready, 1'b1);
    tick();
    res_if.valid = 1'b0;
    chk("ins_inflight0", inflight_o, 8'd0);
    chk("ins_busy0", busy_o, 1'b0);

    host_res_ready_i = 1'b0;
    host_cmd_i = CMD_SEARCH;
    host_valid_i = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      host_key_i = 32'(i);
      #1;
      if (host_ready_o) acc++;
      tick();
    end
    host_valid_i = 1'b0;
    chk("bb_accepts", acc, 8);
    chk("bb_inflight8", inflight_o, 8'd8);
    chk("bb_ready_low", host_ready_o, 1'b0);
    host_res_ready_i = 1'b1;
    res_if.result = '{key: 32'h0, value: 32'h0,
                      cmd: CMD_SEARCH, rescode: SEARCH_NOT_FOUND};
    res_if.valid = 1'b1;
    #1;
    chk("bb_no_lookahead", host_ready_o, 1'b0);
    chk("bb_res_valid", host_res_valid_o, 1'b1);
    tick();
    res_if.valid = 1'b0;
    #1;
    chk("bb_inflight7", inflight_o, 8'd7);
    chk("bb_reopen", host_ready_o, 1'b1);
    res_if.valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    res_if.valid = 1'b0;
    chk("bb_drained", inflight_o, 8'd0);

    task_if.ready = 1'b0;
    host_cmd_i = CMD_DELETE;
    host_key_i = 32'hAAAA;
    host_value_i = 32'h77;
    host_valid_i = 1'b1;
    tick();
    host_key_i = 32'hBBBB;
    host_cmd_i = CMD_INSERT;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", task_if.valid, 1'b1);
      chk("stall_key", task_if.key, 32'hAAAA);
      chk("stall_cmd", task_if.cmd, CMD_DELETE);
      chk("stall_ready", host_ready_o, 1'b0);
      tick();
    end
    host_valid_i = 1'b0;
    task_if.ready = 1'b1;
    tick();
    chk("stall_done", task_if.valid, 1'b0);
    chk("stall_one_accept", inflight_o, 8'd1);
    res_if.valid = 1'b1;
    tick();
    res_if.valid = 1'b0;
    chk("stall_inflight0", inflight_o, 8'd0);

    host_cmd_i = CMD_SEARCH;
    host_key_i = 32'h42;
    host_valid_i = 1'b1;
    tick();
    host_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", err_timeout_o, 1'b0);
    tick();
    chk("to_err", err_timeout_o, 1'b1);
    chk("to_ready_low", host_ready_o, 1'b0);
    chk("to_inflight", inflight_o, 8'd1);
    clear_err_i = 1'b1;
    tick();
    clear_err_i = 1'b0;
    chk("to_clr_err", err_timeout_o, 1'b0);
    chk("to_clr_inflight", inflight_o, 8'd0);
    chk("to_clr_ready", host_ready_o, 1'b1);

    host_res_ready_i = 1'b0;
    res_if.valid = 1'b1;
    #1;
    chk("sp_ready", res_if.ready, 1'b1);
    chk("sp_res_valid", host_res_valid_o, 1'b0);
    tick();
    res_if.valid = 1'b0;
    chk("sp_err", err_unexpected_o, 1'b1);
    clear_err_i = 1'b1;
    tick();
    clear_err_i = 1'b0;
    chk("sp_clr", err_unexpected_o, 1'b0);

    host_res_ready_i = 1'b1;
    host_valid_i = 1'b1;
    tick();
    tick();
    tick();
    host_valid_i = 1'b0;
    chk("fl_inflight3", inflight_o, 8'd3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_ready_low", host_ready_o, 1'b0);
    chk("fl_busy", busy_o, 1'b1);
    res_if.valid = 1'b1;
    tick();
    tick();
    chk("fl_ready_low2", host_ready_o, 1'b0);
    chk("fl_inflight1", inflight_o, 8'd1);
    tick();
    res_if.valid = 1'b0;
    chk("fl_inflight0", inflight_o, 8'd0);
    chk("fl_still_drain", host_ready_o, 1'b0);
    tick();
    chk("fl_run", host_ready_o, 1'b1);

    host_valid_i = 1'b1;
    tick();
    tick();
    host_valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("rd_drain", host_ready_o, 1'b0);
    res_if.valid = 1'b1;
    #1;
    rst_i = 1'b0;
    #1;
    chk("rd_ready", host_ready_o, 1'b1);
    chk("rd_task_valid", task_if.valid, 1'b0);
    chk("rd_inflight", inflight_o, 8'd0);
    chk("rd_busy", busy_o, 1'b0);
    chk("rd_res_valid", host_res_valid_o, 1'b0);
    chk("rd_res_ready", res_if.ready, 1'b1);
    rst_i = 1'b1;
    tick();
    res_if.valid = 1'b0;
    chk("rd_unexpected", err_unexpected_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
